// File: rtl/rr_arb_4_sel_if.sv
// Selection bus between the 4-source round-robin arbiter and its requesters/downstream mux.
// Transfer rule: a selection moves on a rising edge where vld=1 and rdy=1; while vld=1 and rdy=0, sel/gnt/vld are frozen.
interface rr_arb_4_sel_if;
   logic [3:0] req;
   logic       rdy;
`ifdef ARB_LOCK_EN
   logic       lock;
`endif
   logic [1:0] sel;
   logic [3:0] gnt;
   logic       vld;

   // master: the arbiter, which drives the selection; slave: requesters plus downstream consumer
`ifdef ARB_LOCK_EN
   modport master (input req, rdy, lock, output sel, gnt, vld);
   modport slave  (output req, rdy, lock, input sel, gnt, vld);
`else
   modport master (input req, rdy, output sel, gnt, vld);
   modport slave  (output req, rdy, input sel, gnt, vld);
`endif
endinterface

// File: rtl/rr_arb_4_sel.sv
// Four-source round-robin arbiter with sticky registered grant driving a 4:1 mux select.
// Optional grant lock (repeat the current winner) is enabled by defining ARB_LOCK_EN.
module rr_arb_4_sel (
   input  logic           clk,
   input  logic           rst,
   rr_arb_4_sel_if.master bus,
   output logic           dbg_state
);

   typedef enum logic {IDLE = 1'b0, GRANT = 1'b1} state_t;

   state_t     state;
   logic [1:0] sel_q;
   logic [1:0] last;
   logic [3:0] gnt_q;
   logic       vld_q;
   logic [2:0] idle_win;
   logic [2:0] hs_win;
   logic       lock_hold;

   // Returns {found, index}; searches ptr+1, ptr+2, ptr+3, ptr (mod 4).
   function automatic logic [2:0] pick(input logic [3:0] r, input logic [1:0] ptr);
      logic [2:0] res;
      logic [1:0] idx;
      res = 3'b000;
      for (int k = 1; k <= 4; k++) begin
         idx = ptr + k[1:0];
         if (!res[2] && r[idx]) res = {1'b1, idx};
      end
      return res;
   endfunction

   assign idle_win = pick(bus.req, last);
   // On a handshake last becomes sel, so the re-arbitration pointer is sel itself.
   assign hs_win   = pick(bus.req, sel_q);

`ifdef ARB_LOCK_EN
   assign lock_hold = bus.lock & bus.req[sel_q];
`else
   assign lock_hold = 1'b0;
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
         vld_q <= 1'b0;
         gnt_q <= 4'b0000;
         sel_q <= 2'd0;
         last  <= 2'd3;
      end else begin
         case (state)
            IDLE: begin
               if (idle_win[2]) begin
                  state <= GRANT;
                  vld_q <= 1'b1;
                  sel_q <= idle_win[1:0];
                  gnt_q <= 4'b0001 << idle_win[1:0];
               end else begin
                  gnt_q <= 4'b0000;
               end
            end
            GRANT: begin
               // A locked handshake repeats the grant and leaves the pointer alone.
               if (bus.rdy && !lock_hold) begin
                  last <= sel_q;
                  if (hs_win[2]) begin
                     sel_q <= hs_win[1:0];
                     gnt_q <= 4'b0001 << hs_win[1:0];
                  end else begin
                     state <= IDLE;
                     vld_q <= 1'b0;
                     gnt_q <= 4'b0000;
                  end
               end
            end
         endcase
      end
   end

   assign bus.sel   = sel_q;
   assign bus.gnt   = gnt_q;
   assign bus.vld   = vld_q;
   assign dbg_state = (state == GRANT);

endmodule

// File: tb/tb_rr_arb_4_sel.sv
// Bench for rr_arb_4_sel: directed scenarios plus randomized traffic against a round-robin reference model.
module tb_rr_arb_4_sel;

   logic clk = 1'b0;
   logic rst = 1'b0;
   logic dbg_state;

   rr_arb_4_sel_if bus ();

   rr_arb_4_sel dut (
      .clk       (clk),
      .rst       (rst),
      .bus       (bus),
      .dbg_state (dbg_state)
   );

   // ---------------- clock ----------------
   always #5 clk = ~clk;

`ifdef ARB_LOCK_EN
   localparam bit LOCK_ON = 1'b1;
`else
   localparam bit LOCK_ON = 1'b0;
`endif

   // ---------------- scoreboard ----------------
   int n_cmp = 0;
   int n_err = 0;
   logic [6:0] exp_q[$];

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 'h%0h expected 'h%0h at %0t", tag, got, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   bit m_vld;
   int m_sel;
   int m_last;

   function automatic int winner(input logic [3:0] r, input int ptr);
      for (int k = 1; k <= 4; k++)
         if (r[(ptr + k) % 4]) return (ptr + k) % 4;
      return -1;
   endfunction

   task automatic model_reset();
      m_vld  = 1'b0;
      m_sel  = 0;
      m_last = 3;
      exp_q.delete();
   endtask

   task automatic model_edge(input logic [3:0] r, input logic y, input logic l);
      int w;
      if (!m_vld) begin
         w = winner(r, m_last);
         if (w >= 0) begin
            m_vld = 1'b1;
            m_sel = w;
         end
      end else if (y) begin
         if (!(LOCK_ON && l && r[m_sel])) begin
            m_last = m_sel;
            w = winner(r, m_last);
            if (w >= 0) m_sel = w;
            else m_vld = 1'b0;
         end
      end
   endtask

   function automatic logic [6:0] model_out();
      logic [3:0] g;
      logic [1:0] s;
      s = 2'(m_sel);
      g = m_vld ? (4'b0001 << s) : 4'b0000;
      return {m_vld, g, s};
   endfunction

   // ---------------- driver tasks ----------------
   task automatic do_reset();
      rst = 1'b1;
      #1;
      model_reset();
      check("rst_vld", 32'(bus.vld), 32'd0);
      check("rst_gnt", 32'(bus.gnt), 32'd0);
      check("rst_sel", 32'(bus.sel), 32'd0);
      @(posedge clk);
      #1;
      rst = 1'b0;
   endtask

   task automatic step(input logic [3:0] r, input logic y, input logic l);
      logic [6:0] exp;
      bus.req = r;
      bus.rdy = y;
`ifdef ARB_LOCK_EN
      bus.lock = l;
`endif
      model_edge(r, y, l);
      exp_q.push_back(model_out());
      @(posedge clk);
      #1;
      exp = exp_q.pop_front();
      check("out", 32'({bus.vld, bus.gnt, bus.sel}), 32'(exp));
      check("state", 32'(dbg_state), 32'(exp[6]));
   endtask

   // ---------------- invariants ----------------
   logic       hold_prev = 1'b0;
   logic [1:0] sel_prev = 2'd0;

   always @(posedge clk) begin
      hold_prev <= bus.vld && !bus.rdy && !rst;
      sel_prev  <= bus.sel;
   end

   always @(negedge clk) begin
      if (!rst) begin
         assert ($onehot0(bus.gnt)) else $error("gnt not one-hot-or-zero: %b", bus.gnt);
         assert (bus.gnt == (bus.vld ? (4'b0001 << bus.sel) : 4'b0000))
            else $error("gnt %b inconsistent with vld=%b sel=%0d", bus.gnt, bus.vld, bus.sel);
         if (hold_prev)
            assert (bus.sel == sel_prev) else $error("sel moved while stalled: %0d -> %0d", sel_prev, bus.sel);
      end
   end

   // ---------------- stimulus ----------------
   int exp_seq[5] = '{0, 1, 2, 3, 0};

   initial begin
      bus.req = 4'b0000;
      bus.rdy = 1'b0;
`ifdef ARB_LOCK_EN
      bus.lock = 1'b0;
`endif
      #2;
      do_reset();

      // round robin with all sources requesting
      for (int i = 0; i < 5; i++) begin
         step(4'b1111, 1'b1, 1'b0);
         check("rr_seq", 32'(bus.sel), 32'(exp_seq[i]));
         check("rr_vld", 32'(bus.vld), 32'd1);
      end

      // sticky grant while stalled, dropped request, then release to idle
      do_reset();
      step(4'b0100, 1'b0, 1'b0);
      check("sticky_gnt1", 32'(bus.gnt), 32'h4);
      step(4'b0000, 1'b0, 1'b0);
      check("sticky_gnt2", 32'(bus.gnt), 32'h4);
      step(4'b0000, 1'b0, 1'b0);
      check("sticky_gnt3", 32'(bus.gnt), 32'h4);
      step(4'b0000, 1'b1, 1'b0);
      check("release_vld", 32'(bus.vld), 32'd0);
      check("release_gnt", 32'(bus.gnt), 32'd0);
      check("release_sel", 32'(bus.sel), 32'd2);

      // pointer at 1, requesters 0 and 3
      do_reset();
      step(4'b0010, 1'b0, 1'b0);
      step(4'b0000, 1'b1, 1'b0);
      step(4'b1001, 1'b0, 1'b0);
      check("ptr1_sel", 32'(bus.sel), 32'd3);
      step(4'b1001, 1'b1, 1'b0);
      check("wrap_sel", 32'(bus.sel), 32'd0);

      // rdy in idle is ignored, single requester regranted
      do_reset();
      step(4'b0000, 1'b1, 1'b0);
      step(4'b0000, 1'b1, 1'b0);
      for (int i = 0; i < 3; i++) begin
         step(4'b0010, 1'b1, 1'b0);
         check("single_sel", 32'(bus.sel), 32'd1);
      end

      // asynchronous reset mid-grant, then restart from the reset pointer
      do_reset();
      step(4'b0100, 1'b0, 1'b0);
      step(4'b0100, 1'b0, 1'b0);
      check("pre_rst_sel", 32'(bus.sel), 32'd2);
      do_reset();
      step(4'b1111, 1'b0, 1'b0);
      check("post_rst_sel", 32'(bus.sel), 32'd0);

`ifdef ARB_LOCK_EN
      do_reset();
      step(4'b0011, 1'b0, 1'b0);
      step(4'b0011, 1'b1, 1'b1);
      check("lock_sel1", 32'(bus.sel), 32'd0);
      step(4'b0011, 1'b1, 1'b1);
      check("lock_sel2", 32'(bus.sel), 32'd0);
      step(4'b0011, 1'b1, 1'b0);
      check("unlock_sel", 32'(bus.sel), 32'd1);
`endif

      // randomized traffic with occasional resets
      do_reset();
      for (int i = 0; i < 600; i++) begin
         if ($urandom_range(0, 59) == 0)
            do_reset();
         else
            step(4'($urandom_range(0, 15)), $urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
